// File: rtl/arm_ctrl_pkg.sv
// Shared constants for the ARM32 multi-cycle control unit: FSM states,
// opcode field positions, operand-mode codes, condition codes and ALU ops.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_START,
        S_LOAD_PC,
        S_FETCH1,
        S_FETCH2,
        S_DECODE,
        S_EXECUTE,
        S_MEM1,
        S_MEM2,
        S_WB_LDR
    } state_e;

    localparam int OP_MEM_BIT   = 6;
    localparam int OP_MODE_HI   = 5;
    localparam int OP_MODE_LO   = 4;
    localparam int OP_RN_ST_BIT = 3;

    localparam logic [1:0] DP_MODE_REG  = 2'b01;
    localparam logic [1:0] DP_MODE_RS   = 2'b11;
    localparam logic [1:0] MEM_MODE_LIT = 2'b00;
    localparam logic [1:0] MEM_MODE_REG = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] SEL_PC_INC   = 2'b00;
    localparam logic [1:0] SEL_PC_START = 2'b01;
    localparam logic [1:0] SEL_RD_PC    = 2'b11;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: decides whether an instruction executes
// given its cond field and the current NZCV flags. AL and 1111 always pass.
module cond_eval
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multi-cycle FSM control unit of the ARM32 CPU (fetch/decode/execute/mem/wb).
// Define CTRL_COND_EXEC_EN to gate execution on cond vs NZCV; otherwise all run as AL.
module arm_mc_controller
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [31:0] status_reg,
    input  logic [3:0]  cond,
    input  logic        P,
    input  logic        U,
    input  logic        W,
    output logic        waiting,
    output logic        load_ir,
    output logic        load_pc,
    output logic [1:0]  sel_pc,
    output logic        w_en1,
    output logic        w_en2,
    output logic        w_en3,
    output logic        sel_w_data,
    output logic [1:0]  sel_A_in,
    output logic [1:0]  sel_B_in,
    output logic [1:0]  sel_shift_in,
    output logic        en_A,
    output logic        en_B,
    output logic        en_S,
    output logic        en_C,
    output logic        sel_shift,
    output logic        sel_A,
    output logic        sel_B,
    output logic        sel_post_shift,
    output logic [2:0]  ALU_op,
    output logic        en_status1,
    output logic        en_status2,
    output logic        en_out1,
    output logic        en_out2,
    output logic [10:0] ram_addr1,
    output logic [10:0] ram_addr2,
    output logic        ram_w_en1,
    output logic        ram_w_en2
);

    state_e     state_q, state_d;
    logic       first_q, first_d;
    logic       cond_pass;
    logic       is_mem, rn_st;
    logic [1:0] mode;

    assign is_mem = opcode[OP_MEM_BIT];
    assign rn_st  = opcode[OP_RN_ST_BIT];
    assign mode   = opcode[OP_MODE_HI:OP_MODE_LO];

`ifdef CTRL_COND_EXEC_EN
    logic unused_status_bits;
    assign unused_status_bits = ^status_reg[27:0];

    cond_eval u_cond_eval (
        .cond (cond),
        .nzcv (status_reg[31:28]),
        .pass (cond_pass)
    );
`else
    logic unused_cond_inputs;
    assign unused_cond_inputs = ^{cond, status_reg};
    assign cond_pass = 1'b1;
`endif

    // Addresses come from the datapath; these ports are tied off here.
    assign sel_w_data   = 1'b0;
    assign sel_B_in     = 2'b00;
    assign sel_shift_in = 2'b00;
    assign en_status2   = 1'b0;
    assign en_out1      = 1'b0;
    assign en_out2      = 1'b0;
    assign ram_w_en1    = 1'b0;
    assign ram_addr1    = '0;
    assign ram_addr2    = '0;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d        = state_q;
        first_d        = first_q;
        waiting        = 1'b0;
        load_ir        = 1'b0;
        load_pc        = 1'b0;
        sel_pc         = SEL_PC_INC;
        w_en1          = 1'b0;
        w_en2          = 1'b0;
        w_en3          = 1'b0;
        sel_A_in       = 2'b00;
        en_A           = 1'b0;
        en_B           = 1'b0;
        en_S           = 1'b0;
        en_C           = 1'b0;
        sel_shift      = 1'b0;
        sel_A          = 1'b0;
        sel_B          = 1'b0;
        sel_post_shift = 1'b0;
        ALU_op         = ALU_ADD;
        en_status1     = 1'b0;
        ram_w_en2      = 1'b0;

        case (state_q)
            S_START: begin
                waiting = 1'b1;
                state_d = S_LOAD_PC;
            end
            S_LOAD_PC: begin
                waiting = 1'b1;
                load_pc = 1'b1;
                sel_pc  = first_q ? SEL_PC_START : SEL_PC_INC;
                first_d = 1'b0;
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                waiting = 1'b1;
                state_d = S_FETCH2;
            end
            S_FETCH2: begin
                waiting = 1'b1;
                load_ir = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (!cond_pass) begin
                    state_d = S_LOAD_PC;
                end else begin
                    state_d = S_MEM1;
                    if (is_mem) begin
                        en_A      = 1'b1;
                        sel_A_in  = (mode == MEM_MODE_LIT) ? SEL_RD_PC : 2'b00;
                        en_B      = (mode == MEM_MODE_REG);
                        en_S      = (mode == MEM_MODE_REG);
                        sel_shift = (mode == MEM_MODE_REG);
                    end else begin
                        en_A      = rn_st;
                        en_B      = (mode == DP_MODE_REG) || (mode == DP_MODE_RS);
                        en_S      = (mode == DP_MODE_REG) || (mode == DP_MODE_RS);
                        sel_shift = (mode == DP_MODE_RS);
                    end
                end
            end
            S_MEM1: begin
                en_C    = 1'b1;
                state_d = S_MEM2;
                if (is_mem) begin
                    sel_B          = (mode != MEM_MODE_REG);
                    sel_post_shift = ~P;
                    ALU_op         = U ? ALU_ADD : ALU_SUB;
                    ram_w_en2      = rn_st;
                end else begin
                    sel_A      = ~rn_st;
                    sel_B      = ~mode[0];
                    ALU_op     = opcode[2:0];
                    w_en1      = 1'b1;
                    en_status1 = 1'b1;
                end
            end
            S_MEM2: begin
                // Base writeback for post-index or pre-index with W; literals have no base.
                w_en2   = is_mem && (~P || W) && (mode != MEM_MODE_LIT);
                state_d = (is_mem && !rn_st) ? S_WB_LDR : S_LOAD_PC;
            end
            S_WB_LDR: begin
                w_en3   = 1'b1;
                state_d = S_LOAD_PC;
            end
            default: state_d = S_START;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench for arm_mc_controller: hand sequences, a vector table
// of named instructions, and randomized instructions against a per-instruction model.
module tb_arm_mc_controller;

    typedef struct packed {
        logic        waiting;
        logic        load_ir;
        logic        load_pc;
        logic [1:0]  sel_pc;
        logic        w_en1;
        logic        w_en2;
        logic        w_en3;
        logic        sel_w_data;
        logic [1:0]  sel_A_in;
        logic [1:0]  sel_B_in;
        logic [1:0]  sel_shift_in;
        logic        en_A;
        logic        en_B;
        logic        en_S;
        logic        en_C;
        logic        sel_shift;
        logic        sel_A;
        logic        sel_B;
        logic        sel_post_shift;
        logic [2:0]  ALU_op;
        logic        en_status1;
        logic        en_status2;
        logic        en_out1;
        logic        en_out2;
        logic [10:0] ram_addr1;
        logic [10:0] ram_addr2;
        logic        ram_w_en1;
        logic        ram_w_en2;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       p, u, w;
        logic [3:0] ex_en;        // {en_A, en_B, en_S, sel_shift}
        logic [1:0] ex_sel_a_in;
        logic [9:0] m1;           // {sel_A, sel_B, sel_post_shift, ALU_op, w_en1, ram_w_en2, en_C, en_status1}
        logic       m2_w_en2;
        logic       has_wb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [6:0]  opcode;
    logic [31:0] status_reg;
    logic [3:0]  cond;
    logic        P, U, W;
    logic        waiting, load_ir, load_pc, w_en1, w_en2, w_en3, sel_w_data;
    logic [1:0]  sel_pc, sel_A_in, sel_B_in, sel_shift_in;
    logic        en_A, en_B, en_S, en_C, sel_shift, sel_A, sel_B, sel_post_shift;
    logic [2:0]  ALU_op;
    logic        en_status1, en_status2, en_out1, en_out2, ram_w_en1, ram_w_en2;
    logic [10:0] ram_addr1, ram_addr2;

    int vectors = 0;
    int miscompares = 0;
    outs_t act;
    outs_t exp_q[$];
    vec_t  tv[9];

    always #5 clk = ~clk;

    arm_mc_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .status_reg(status_reg), .cond(cond),
        .P(P), .U(U), .W(W), .waiting(waiting), .load_ir(load_ir), .load_pc(load_pc),
        .sel_pc(sel_pc), .w_en1(w_en1), .w_en2(w_en2), .w_en3(w_en3), .sel_w_data(sel_w_data),
        .sel_A_in(sel_A_in), .sel_B_in(sel_B_in), .sel_shift_in(sel_shift_in),
        .en_A(en_A), .en_B(en_B), .en_S(en_S), .en_C(en_C), .sel_shift(sel_shift),
        .sel_A(sel_A), .sel_B(sel_B), .sel_post_shift(sel_post_shift), .ALU_op(ALU_op),
        .en_status1(en_status1), .en_status2(en_status2), .en_out1(en_out1), .en_out2(en_out2),
        .ram_addr1(ram_addr1), .ram_addr2(ram_addr2), .ram_w_en1(ram_w_en1), .ram_w_en2(ram_w_en2)
    );

    assign act = {waiting, load_ir, load_pc, sel_pc, w_en1, w_en2, w_en3, sel_w_data,
                  sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, en_C, sel_shift,
                  sel_A, sel_B, sel_post_shift, ALU_op, en_status1, en_status2, en_out1,
                  en_out2, ram_addr1, ram_addr2, ram_w_en1, ram_w_en2};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [3:0] c, input logic [3:0] nzcv,
                         input logic p, input logic u, input logic w);
        opcode     = op;
        cond       = c;
        status_reg = {nzcv, 28'($urandom())};
        P = p;
        U = u;
        W = w;
    endtask

    function automatic outs_t blank();
        outs_t o;
        o = '0;
        return o;
    endfunction

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
`ifdef CTRL_COND_EXEC_EN
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
`else
        return 1'b1 | ^{c, f};
`endif
    endfunction

    // Builds the cycle-by-cycle expected outputs for one whole instruction.
    task automatic build_expected(input logic [6:0] op, input logic [3:0] c, input logic [3:0] nzcv,
                                  input logic p, input logic u, input logic w, input bit first);
        outs_t o;
        bit mem, store, runs;
        int m;
        mem   = op[6];
        store = op[3];
        m     = int'(op[5:4]);
        runs  = cond_holds(c, nzcv);
        exp_q.delete();
        o = blank(); o.waiting = 1; o.load_pc = 1; o.sel_pc = first ? 2'd1 : 2'd0; exp_q.push_back(o);
        o = blank(); o.waiting = 1; exp_q.push_back(o);
        o = blank(); o.waiting = 1; o.load_ir = 1; exp_q.push_back(o);
        o = blank(); exp_q.push_back(o);
        o = blank();
        if (runs) begin
            if (mem) begin
                o.en_A = 1;
                o.sel_A_in = (m == 0) ? 2'd3 : 2'd0;
                o.en_B = (m == 3); o.en_S = (m == 3); o.sel_shift = (m == 3);
            end else begin
                o.en_A = op[3];
                o.en_B = (m == 1 || m == 3); o.en_S = (m == 1 || m == 3);
                o.sel_shift = (m == 3);
            end
        end
        exp_q.push_back(o);
        if (!runs) return;
        o = blank(); o.en_C = 1;
        if (mem) begin
            o.sel_B = (m != 3); o.sel_post_shift = !p;
            o.ALU_op = u ? 3'd0 : 3'd1; o.ram_w_en2 = store;
        end else begin
            o.sel_A = !op[3]; o.sel_B = (m == 0 || m == 2);
            o.ALU_op = op[2:0]; o.w_en1 = 1; o.en_status1 = 1;
        end
        exp_q.push_back(o);
        o = blank(); o.w_en2 = mem && (!p || w) && (m != 0); exp_q.push_back(o);
        if (mem && !store) begin
            o = blank(); o.w_en3 = 1; exp_q.push_back(o);
        end
    endtask

    task automatic run_model(input string tag, input logic [6:0] op, input logic [3:0] c,
                             input logic [3:0] nzcv, input logic p, input logic u, input logic w,
                             input bit first);
        drive(op, c, nzcv, p, u, w);
        build_expected(op, c, nzcv, p, u, w, first);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check($sformatf("%s_cyc%0d", tag, k), 64'(act), 64'(exp_q[k]));
            step();
        end
    endtask

    initial begin
        outs_t e;
        tv[0] = '{7'b0011000, 0, 0, 0, 4'b1110, 2'b00, 10'b0_0_0_000_1_0_1_1, 0, 0}; // ADD_R
        tv[1] = '{7'b0010000, 0, 0, 0, 4'b0110, 2'b00, 10'b1_0_0_000_1_0_1_1, 0, 0}; // MOV_R
        tv[2] = '{7'b0111001, 0, 0, 0, 4'b1111, 2'b00, 10'b0_0_0_001_1_0_1_1, 0, 0}; // SUB_RS
        tv[3] = '{7'b1000010, 0, 1, 0, 4'b1000, 2'b11, 10'b0_1_1_000_0_0_1_0, 0, 1}; // LDR_LIT
        tv[4] = '{7'b1111110, 1, 1, 0, 4'b1111, 2'b00, 10'b0_0_0_000_0_1_1_0, 0, 0}; // STR_R
        tv[5] = '{7'b1010000, 0, 0, 0, 4'b1000, 2'b00, 10'b0_1_1_001_0_0_1_0, 1, 1}; // LDR imm post, down
        tv[6] = '{7'b1101000, 1, 1, 1, 4'b1000, 2'b00, 10'b0_1_0_000_0_1_1_0, 1, 0}; // STR imm pre, wb
        tv[7] = '{7'b0000010, 0, 0, 0, 4'b0000, 2'b00, 10'b1_1_0_010_1_0_1_1, 0, 0}; // dp imm, no Rn
        tv[8] = '{7'b0101011, 0, 0, 0, 4'b1000, 2'b00, 10'b0_1_0_011_1_0_1_1, 0, 0}; // dp imm mode 10

        rst_n = 1'b0;
        drive(7'd0, 4'b1110, 4'd0, 0, 0, 0);
        #2;
        e = blank(); e.waiting = 1;
        check("reset_start", 64'(act), 64'(e));
        #10 rst_n = 1'b1;
        step();

        // Boot sequence: first LOAD_PC selects the start PC, later ones PC+4.
        e = blank(); e.waiting = 1; e.load_pc = 1; e.sel_pc = 2'b01;
        check("boot_load_pc", 64'(act), 64'(e));
        step();
        e = blank(); e.waiting = 1;
        check("boot_fetch1", 64'(act), 64'(e));
        step();
        e = blank(); e.waiting = 1; e.load_ir = 1;
        check("boot_fetch2", 64'(act), 64'(e));
        step();
        check("boot_decode_waiting", 64'(waiting), 64'(0));
        repeat (4) step();
        check("second_load_pc", 64'({waiting, load_pc, sel_pc}), 64'(4'b1100));

        foreach (tv[i]) begin
            drive(tv[i].op, 4'b1110, 4'd0, tv[i].p, tv[i].u, tv[i].w);
            repeat (4) step();
            check($sformatf("tv%0d_execute", i), 64'({en_A, en_B, en_S, sel_shift, sel_A_in}),
                  64'({tv[i].ex_en, tv[i].ex_sel_a_in}));
            step();
            check($sformatf("tv%0d_mem1", i),
                  64'({sel_A, sel_B, sel_post_shift, ALU_op, w_en1, ram_w_en2, en_C, en_status1}),
                  64'(tv[i].m1));
            step();
            check($sformatf("tv%0d_mem2_w_en2", i), 64'(w_en2), 64'(tv[i].m2_w_en2));
            step();
            if (tv[i].has_wb) begin
                check($sformatf("tv%0d_wb_w_en3", i), 64'({w_en3, load_pc}), 64'(2'b10));
                step();
            end
            check($sformatf("tv%0d_next_load_pc", i), 64'({load_pc, sel_pc, w_en3}), 64'(4'b1000));
        end

        // EQ with Z clear: skipped when conditional execution is built in, runs otherwise.
        drive(7'b0011000, 4'b0000, 4'b0000, 0, 0, 0);
        repeat (4) step();
`ifdef CTRL_COND_EXEC_EN
        check("cond_fail_execute", 64'({en_A, en_B, en_S}), 64'(3'b000));
        step();
        check("cond_fail_back_to_load_pc", 64'({load_pc, w_en1}), 64'(2'b10));
`else
        check("cond_ignored_execute", 64'({en_A, en_B, en_S}), 64'(3'b111));
        step();
        check("cond_ignored_mem1", 64'({load_pc, w_en1}), 64'(2'b01));
        repeat (2) step();
`endif

        // Input change inside MEM1 must only move that state's combinational outputs.
        drive(7'b0011000, 4'b1110, 4'd0, 0, 0, 0);
        repeat (5) step();
        opcode = 7'b0011101;
        #1;
        check("midstate_alu_op", 64'({ALU_op, w_en1}), 64'(4'b1011));
        step();
        check("midstate_mem2", 64'({w_en2, load_pc}), 64'(2'b00));
        step();

        for (int i = 0; i < 150; i++) begin
            run_model($sformatf("rand%0d", i), 7'($urandom()), 4'($urandom()), 4'($urandom()),
                      1'($urandom()), 1'($urandom()), 1'($urandom()), 1'b0);
        end

        // Reset in the middle of an instruction restarts from START with the start PC.
        drive(7'b1111110, 4'b1110, 4'd0, 1, 1, 0);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        e = blank(); e.waiting = 1;
        check("midop_reset_start", 64'(act), 64'(e));
        #3 rst_n = 1'b1;
        step();
        run_model("after_reset", 7'b1000010, 4'b1110, 4'd0, 0, 1, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
